// File: rtl/frame_drawer.sv
// frame_drawer
// Walks the playfield in raster order once per frame_clk rising edge, drives
// PixelX/PixelY into the sprite modules, registers the returned sprite ROM
// address, and writes the resolved palette index into the frame buffer.
//
// Ports
//   Clk          system clock, all logic on posedge
//   Reset        synchronous, active-high
//   frame_clk    asynchronous frame tick; a rising edge starts one frame
//   is_obj       sprite hit for the presented pixel (same-cycle valid)
//   Obj_address  sprite ROM address for the presented pixel (same-cycle valid)
//   Rom_data     sprite ROM read data, one cycle after Rom_address
//   PixelX/Y     scan coordinate presented to the sprite modules
//   Rom_address  registered Obj_address
//   Fb_we        frame-buffer write strobe
//   Fb_addr      linear frame-buffer address y*H_RES+x
//   Fb_data      palette index written with Fb_we
//   Busy         high from the first scan cycle through the last write
//   Done         one-cycle pulse after the final write
module frame_drawer #(
    parameter int unsigned H_RES       = 320,
    parameter int unsigned V_RES       = 240,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned TRANSPARENT = 0,
    parameter int unsigned BG_INDEX    = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               is_obj,
    input  logic [12:0]        Obj_address,
    input  logic [COLOR_W-1:0] Rom_data,
    output logic [8:0]         PixelX,
    output logic [8:0]         PixelY,
    output logic [12:0]        Rom_address,
    output logic               Fb_we,
    output logic [16:0]        Fb_addr,
    output logic [COLOR_W-1:0] Fb_data,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned X_W = 9;
    localparam int unsigned Y_W = 9;
    localparam int unsigned A_W = 17;
    localparam int unsigned R_W = 13;

    localparam logic [X_W-1:0]     LAST_X  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]     LAST_Y  = Y_W'(V_RES - 1);
    localparam logic [COLOR_W-1:0] TRANS_C = COLOR_W'(TRANSPARENT);
    localparam logic [COLOR_W-1:0] BG_C    = COLOR_W'(BG_INDEX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Frame tick synchroniser and rising-edge detector.
    logic fc_sync_q;
    logic fc_dly_q;
    logic start_q;

    // Scan state.
    logic [1:0]     state_q, state_d;
    logic [X_W-1:0] px_q, px_d;
    logic [Y_W-1:0] py_q, py_d;
    logic [A_W-1:0] cnt_q, cnt_d;
    logic           drain_q, drain_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pix_valid_c;

    // Pipeline stage 1 (ROM address phase) and stage 2 (write phase).
    logic           v1_q;
    logic           obj1_q;
    logic [R_W-1:0] rom_addr_q;
    logic [A_W-1:0] a1_q;
    logic           we_q;
    logic           obj2_q;
    logic [A_W-1:0] fb_addr_q;

    // frame_clk is asynchronous: sample once, then compare against the previous sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_sync_q <= 1'b0;
            fc_dly_q  <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            fc_sync_q <= frame_clk;
            fc_dly_q  <= fc_sync_q;
            start_q   <= fc_sync_q & ~fc_dly_q;
        end
    end

    // State and scan registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and scan counter logic; starts outside IDLE are dropped.
    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_SCAN;
                    px_d    = '0;
                    py_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                pix_valid_c = 1'b1;
                // Running linear address avoids a y*H_RES multiplier.
                cnt_d = cnt_q + A_W'(1);
                if (px_q == LAST_X) begin
                    px_d = '0;
                    if (py_q == LAST_Y) begin
                        py_d    = '0;
                        cnt_d   = '0;
                        drain_d = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        py_d = py_q + Y_W'(1);
                    end
                end else begin
                    px_d = px_q + X_W'(1);
                end
            end
            S_DRAIN: begin
                // Two cycles let the last pixel clear both pipeline stages.
                if (drain_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Stage 1 captures the sprite response for the pixel presented this cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_q       <= 1'b0;
            obj1_q     <= 1'b0;
            rom_addr_q <= '0;
            a1_q       <= '0;
        end else begin
            v1_q   <= pix_valid_c;
            obj1_q <= pix_valid_c & is_obj;
            a1_q   <= cnt_q;
            if (pix_valid_c) begin
                rom_addr_q <= Obj_address;
            end
        end
    end

    // Stage 2 lines up with the ROM's one-cycle read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            we_q      <= 1'b0;
            obj2_q    <= 1'b0;
            fb_addr_q <= '0;
        end else begin
            we_q      <= v1_q;
            obj2_q    <= obj1_q;
            fb_addr_q <= a1_q;
        end
    end

    // Rom_data only arrives in the write cycle, so the colour select is a mux
    // on registered qualifiers; it is forced to zero whenever no write occurs.
    always_comb begin
        Fb_data = '0;
        if (we_q) begin
            if (obj2_q && (Rom_data != TRANS_C)) begin
                Fb_data = Rom_data;
            end else begin
                Fb_data = BG_C;
            end
        end
    end

    assign PixelX      = px_q;
    assign PixelY      = py_q;
    assign Rom_address = rom_addr_q;
    assign Fb_we       = we_q;
    assign Fb_addr     = fb_addr_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_frame_drawer.sv
// Self-checking bench for frame_drawer on a reduced 32x24 playfield.
module tb_frame_drawer;

    localparam int unsigned H  = 32;
    localparam int unsigned V  = 24;
    localparam int unsigned N  = H * V;
    localparam int unsigned CW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_clk;
    logic          is_obj;
    logic [12:0]   Obj_address;
    logic [CW-1:0] Rom_data;
    logic [8:0]    PixelX;
    logic [8:0]    PixelY;
    logic [12:0]   Rom_address;
    logic          Fb_we;
    logic [16:0]   Fb_addr;
    logic [CW-1:0] Fb_data;
    logic          Busy;
    logic          Done;

    always #5 Clk = ~Clk;

    frame_drawer #(
        .H_RES(H), .V_RES(V), .COLOR_W(CW), .TRANSPARENT(0), .BG_INDEX(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .is_obj(is_obj), .Obj_address(Obj_address), .Rom_data(Rom_data),
        .PixelX(PixelX), .PixelY(PixelY), .Rom_address(Rom_address),
        .Fb_we(Fb_we), .Fb_addr(Fb_addr), .Fb_data(Fb_data),
        .Busy(Busy), .Done(Done)
    );

    int mode = 0;
    int cyc = 0;
    int total = 0;
    int passed = 0;
    int failed = 0;
    int wr_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    logic [20:0]   sb[$];
    logic [CW-1:0] cap[N];

    function automatic logic [12:0] objaddr(input int x, input int y);
        return 13'(x * 7 + y * 3 + 1);
    endfunction

    function automatic logic in_box(input int x, input int y);
        return (x >= 5) && (x <= 12) && (y >= 3) && (y <= 8);
    endfunction

    // Mode 0: no sprite. 1: box, ROM=5. 2: box, ROM=0. 3: everywhere, ROM=addr[3:0].
    function automatic logic [CW-1:0] exp_data(input int m, input int x, input int y);
        logic [12:0]   a;
        logic [CW-1:0] v;
        a = objaddr(x, y);
        v = a[3:0];
        case (m)
            1:       return in_box(x, y) ? 4'd5 : 4'd1;
            3:       return (v == 4'd0) ? 4'd1 : v;
            default: return 4'd1;
        endcase
    endfunction

    // Sprite module model: combinational response to the scan coordinate.
    always_comb begin
        Obj_address = objaddr(int'(PixelX), int'(PixelY));
        case (mode)
            1, 2:    is_obj = in_box(int'(PixelX), int'(PixelY));
            3:       is_obj = 1'b1;
            default: is_obj = 1'b0;
        endcase
    end

    // Synchronous sprite ROM model.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (mode == 1)      Rom_data <= 4'd5;
        else if (mode == 3) Rom_data <= Rom_address[3:0];
        else                Rom_data <= 4'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every frame-buffer write.
    always @(negedge Clk) begin
        if (Fb_we) begin
            wr_count++;
            if (Fb_addr < 17'(N)) cap[Fb_addr] = Fb_data;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(sb.size() > 0), 32'd1);
            end else begin
                check("write", 32'({Fb_addr, Fb_data}), 32'(sb.pop_front()));
            end
        end
        if (Done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic push_frame(input int m);
        for (int y = 0; y < int'(V); y++)
            for (int x = 0; x < int'(H); x++)
                sb.push_back({17'(y * int'(H) + x), exp_data(m, x, y)});
    endtask

    task automatic run_frame(input int m, input int extra_edge_at, input int rst_at);
        int k;
        int s;
        int d0;
        @(negedge Clk);
        mode = m;
        push_frame(m);
        d0 = done_count;
        wr_count = 0;
        frame_clk = 1'b1;
        k = cyc + 1;
        s = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Busy) begin
                s = cyc;
                break;
            end
        end
        check("scan_start_latency", 32'(s - k), 32'd2);
        check("first_pixel", 32'({PixelX, PixelY}), 32'd0);
        frame_clk = 1'b0;
        if (extra_edge_at > 0) begin
            while (cyc < s + extra_edge_at) @(negedge Clk);
            frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            frame_clk = 1'b0;
        end
        if (rst_at > 0) begin
            while (cyc < s + rst_at) @(negedge Clk);
            Reset = 1'b1;
            @(negedge Clk);
            check("rst_fb_we", 32'(Fb_we), 32'd0);
            check("rst_pixel", 32'({PixelX, PixelY}), 32'd0);
            check("rst_busy", 32'(Busy), 32'd0);
            check("rst_fb_data", 32'(Fb_data), 32'd0);
            sb.delete();
            Reset = 1'b0;
            repeat (20) @(negedge Clk);
            check("rst_no_done", 32'(done_count), 32'(d0));
            check("rst_write_count", 32'(wr_count), 32'(rst_at - 1));
            return;
        end
        for (int i = 0; i < int'(N) + 100; i++) begin
            @(negedge Clk);
            if (done_count != d0) break;
        end
        check("done_latency", 32'(done_cyc - s), 32'(N + 2));
        check("busy_at_done", 32'(Busy), 32'd0);
        repeat (3) @(negedge Clk);
        check("write_count", 32'(wr_count), 32'(N));
        check("done_once", 32'(done_count - d0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("idle_pixel", 32'({PixelX, PixelY}), 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_fb_we", 32'(Fb_we), 32'd0);
        check("reset_fb_addr", 32'(Fb_addr), 32'd0);
        check("reset_fb_data", 32'(Fb_data), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_pixel", 32'({PixelX, PixelY}), 32'd0);
        check("reset_rom_addr", 32'(Rom_address), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("idle_no_busy", 32'(Busy), 32'd0);

        run_frame(0, 0, 0);
        run_frame(1, 0, 0);
        check("box_first", 32'(cap[3 * H + 5]), 32'd5);
        check("box_before", 32'(cap[3 * H + 4]), 32'd1);
        check("box_after", 32'(cap[3 * H + 13]), 32'd1);
        check("box_last", 32'(cap[8 * H + 12]), 32'd5);
        run_frame(2, 0, 0);
        run_frame(3, 100, 0);
        run_frame(0, 0, 50);
        run_frame(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_drawer.md
# frame_drawer

Per-frame pixel scanner and frame-buffer writer for the boxhead display path. On each frame_clk rising edge it walks the 320x240 playfield in raster order and drives PixelX/PixelY into the sprite modules (player and the other sprite modules). It takes back is_obj/Obj_address, fetches the palette index from the synchronous sprite ROM, and writes either the sprite colour or the background index into the frame buffer. It is the consumer side of the sprite pixel interface.

## Interface
- H_RES, 320: pixels per line.
- V_RES, 240: lines per frame.
- COLOR_W, 4: palette index width.
- TRANSPARENT, 0: sprite ROM index treated as see-through.
- BG_INDEX, 1: index written where no opaque sprite pixel exists.
- Clk  in  1  50 MHz system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  frame tick (~60 Hz), asynchronous level; rising edge starts a frame.
- is_obj  in  1  combinational from sprite module, valid in the same cycle as PixelX/PixelY.
- Obj_address  in  13  sprite ROM address, same-cycle valid.
- Rom_data  in  COLOR_W  sprite ROM read data, 1-cycle latency after Rom_address.
- PixelX  out  9  current scan column, 0..H_RES-1.
- PixelY  out  9  current scan line, 0..V_RES-1.
- Rom_address  out  13  registered Obj_address.
- Fb_we  out  1  frame-buffer write strobe.
- Fb_addr  out  17  linear address y*H_RES+x.
- Fb_data  out  COLOR_W  write data.
- Busy  out  1  high from the first SCAN cycle through the last write.
- Done  out  1  one-cycle pulse after the final write.

## Operation
- Reset: state IDLE, PixelX=PixelY=0, Rom_address=0, Fb_we=0, Fb_addr=0, Fb_data=0, Busy=0, Done=0, pipeline valids cleared, edge detector cleared.
- Edge detect: frame_clk_delayed <= frame_clk; start <= frame_clk & ~frame_clk_delayed. Both are registered.
- States: IDLE -> SCAN on start. SCAN -> DRAIN after pixel (H_RES-1, V_RES-1) is issued. DRAIN lasts 2 cycles -> DONE. DONE lasts 1 cycle (Done=1) -> IDLE.
- A start seen in SCAN, DRAIN or DONE is dropped, not queued.
- SCAN, each cycle:
  - Present PixelX/PixelY.
  - Advance X. At X=H_RES-1, wrap X to 0 and increment Y.
- Pipeline stage 1 (registered from the scan cycle): v1, is_obj1, Rom_address <= Obj_address, a1 <= linear address.
- Linear address uses a running counter incremented by 1 per pixel. No multiplier.
- Pipeline stage 2: Fb_we <= v1. Fb_addr <= a1.
- Fb_data, computed from Rom_data at stage 2:
  - Rom_data when is_obj1=1 and Rom_data != TRANSPARENT.
  - Otherwise BG_INDEX.
- Fb_we only ever asserts for in-range addresses 0..H_RES*V_RES-1. Each address is written exactly once per frame.
- Reset mid-operation: the next cycle is in the IDLE reset state. No further writes occur, and Done does not pulse.

## Timing
- Let frame_clk first be sampled high at edge k (it was low at k-1).
  - start=1 after edge k+1.
  - State=SCAN after edge k+2. Call this scan cycle S: PixelX=0, PixelY=0, Busy=1.
- Pixel n (n = y*H_RES + x) is presented in cycle S+n.
- Rom_address for pixel n is valid in S+n+1.
- Fb_we=1 with Fb_addr=n in S+n+2.
- Last write (n=76799) occurs in S+76801. Done=1 and Busy=0 in S+76802.
- Throughput is one pixel per cycle, so a frame takes 76803 cycles, well under the 833k-cycle frame period.
- PixelX/PixelY hold 0,0 outside SCAN.

## Test plan
- Reset, no sprite (is_obj=0): pulse frame_clk -> exactly 76800 writes, addresses 0..76799 in order, all Fb_data=1. Done pulses once, 76802 cycles after the first SCAN cycle.
- Sprite model with is_obj=1 for x 151..168 and y 110..129, ROM returning index 5 -> Fb_addr 110*320+151=35351 gets data 5. Addresses 35350 and 35352+17=35369 get 1.
- Transparency: ROM returns 0 inside the sprite box -> every write has Fb_data=1.
- ROM latency: a ROM model that returns Rom_address[3:0] one cycle late, with is_obj always 1 -> write n carries data = (registered Obj_address of pixel n)[3:0]. This checks stage alignment.
- Second frame_clk edge at S+1000 -> ignored. Write count stays 76800, with a single Done.
- Reset asserted at S+500 -> Fb_we=0 from the next cycle, PixelX=PixelY=0, Busy=0, no Done. A following frame_clk edge restarts the scan at address 0.
